pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline register, successor to the fixed ID/EX-style latch.
- Carries a control field and a datapath payload between any two pipeline stages.
- Adds valid/ready back-pressure through a 2-entry skid buffer, so `in_ready` is registered.
- Flush squashes every in-flight entry and forces the control bits to a bubble (all zero).

Parameters:
- DATA_W, 256: datapath payload width (operands, immediate, PC, register indices, packed by the caller).
- CTRL_W, 8: control-bit width (MemRead, MemWrite, RegWrite, branch, ...). These bits are zeroed on bubble or flush.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all stored entries.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat. Registered, equal to ~skid_valid.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  main control. Forced to 0 whenever out_valid=0.
- out_data  out  DATA_W  main payload.
- occupancy  out  2  number of stored entries, 0..2.

Behaviour:
- Storage: main entry M (drives outputs) and skid entry S. Each has a valid bit, a ctrl field and a data field.
- Reset (async): M and S are invalid with ctrl=0 and data=0. Resulting outputs: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0.
- acc = in_valid & in_ready. xfer = out_valid & out_ready.
- Non-flush cycle update rules, evaluated at the clock edge:
  - M empty or xfer, S valid: M<=S. If acc then S<=in, else S invalid.
  - M empty or xfer, S empty: if acc then M<=in, else M invalid.
  - M valid and no xfer: M holds. If acc then S<=in; S must have been empty, which is guaranteed by in_ready.
- Latency: 1 cycle from accept into an empty stage to out_valid=1. Sustained throughput is 1 beat/cycle when out_ready=1.
- Ordering is strictly FIFO. No beat is ever dropped or duplicated outside a flush.
- in_ready deasserts on the cycle after S fills. It reasserts on the cycle after S drains into M.
- Flush has highest priority:
  - M and S go invalid and their ctrl fields go to 0. Data fields hold.
  - Any beat presented in the flush cycle is discarded, even if in_ready=1.
  - A downstream xfer in the flush cycle still completes.
  - in_ready=1 on the following cycle.
- out_ctrl = M_valid ? M_ctrl : 0, so an empty stage always looks like a NOP downstream.
- occupancy = M_valid + S_valid.
- reset asserted mid-stream clears everything immediately, independent of clk.

Optional Feature:
- Macro: PIPE_STAT_EN.
- Defined:
  - Adds output stall_cnt [31:0]: counts cycles with out_valid & ~out_ready.
  - Adds output flush_cnt [15:0]: counts flush cycles in which occupancy was nonzero.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: both ports and all counter logic are absent. Core behaviour is identical.

Test Plan (DATA_W=64, CTRL_W=8):
- Streaming: out_ready=1, push data 1..8 with ctrl=8'h05 every cycle. Expect out_data 1..8 in order, each one cycle after acceptance, in_ready=1 throughout, occupancy<=1.
- Back-pressure: out_ready=0, push A=0x11 then B=0x22, then present C=0x33. Expect in_ready=0 after B, occupancy=2, C held upstream. Then out_ready=1: expect A, B, C in order with no loss.
- Flush with full buffer: occupancy=2, assert flush with in_valid=1, data 0x44. Expect next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; 0x44 never appears at the output.
- Async reset mid-stream: assert reset between clock edges while occupancy=2. Expect outputs cleared before the next edge. After release, the first pushed beat emerges with 1-cycle latency.
- Bubble: no input for 3 cycles. Expect out_valid=0 and out_ctrl=8'h00 while out_data holds its last value.
- PIPE_STAT_EN: hold out_ready=0 for 5 cycles with a valid entry, then flush once. Expect stall_cnt=5 and flush_cnt=1. With the macro undefined, the build has no counter ports.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: parametrised inter-stage pipeline register with valid/ready
// back-pressure through a 2-entry skid buffer.
//
// Storage is a main entry M, which drives the outputs, and a skid entry S.
// S catches the one beat that can still be accepted after downstream stalls,
// because in_ready is a flop and lags one cycle behind.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   flush      in   synchronous squash of all stored entries (highest priority)
//   in_valid   in   upstream beat present
//   in_ready   out  stage can accept a beat (registered, equals ~S valid)
//   in_ctrl    in   [CTRL_W] upstream control bits
//   in_data    in   [DATA_W] upstream payload
//   out_valid  out  main entry valid
//   out_ready  in   downstream accepts
//   out_ctrl   out  [CTRL_W] main control bits, zero whenever out_valid=0
//   out_data   out  [DATA_W] main payload (holds its last value on a bubble)
//   occupancy  out  [2] number of stored entries, 0..2
//
// Optional feature, macro PIPE_STAT_EN:
//   stall_cnt  out  [32] saturating count of cycles with out_valid & ~out_ready
//   flush_cnt  out  [16] saturating count of flush cycles with occupancy != 0
module pipe_stage_buf #(
  parameter int DATA_W = 256,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic              in_ready_q, in_ready_d;

  logic acc;
  logic xfer;

  assign acc  = in_valid & in_ready_q;
  assign xfer = m_valid_q & out_ready;

  // Next-state for both entries. Flush wins over everything and leaves the
  // data fields alone so a squashed stage still shows its last payload.
  // When M frees up (empty or transferring) the skid entry moves forward first
  // so ordering stays FIFO; otherwise a new beat can only land in S.
  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
      s_valid_d = 1'b0;
      s_ctrl_d  = '0;
    end else if (!m_valid_q || xfer) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = s_ctrl_q;
        m_data_d  = s_data_q;
        if (acc) begin
          s_valid_d = 1'b1;
          s_ctrl_d  = in_ctrl;
          s_data_d  = in_data;
        end else begin
          s_valid_d = 1'b0;
        end
      end else if (acc) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = in_ctrl;
        m_data_d  = in_data;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (acc) begin
      s_valid_d = 1'b1;
      s_ctrl_d  = in_ctrl;
      s_data_d  = in_data;
    end
    // Registered ready tracks the skid entry's next state, so it drops the
    // cycle after S fills and rises the cycle after S drains.
    in_ready_d = ~s_valid_d;
  end

  // Storage flops; reset empties both entries and opens the input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_q  <= 1'b0;
      m_ctrl_q   <= '0;
      m_data_q   <= '0;
      s_valid_q  <= 1'b0;
      s_ctrl_q   <= '0;
      s_data_q   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      m_valid_q  <= m_valid_d;
      m_ctrl_q   <= m_ctrl_d;
      m_data_q   <= m_data_d;
      s_valid_q  <= s_valid_d;
      s_ctrl_q   <= s_ctrl_d;
      s_data_q   <= s_data_d;
      in_ready_q <= in_ready_d;
    end
  end

  // An empty stage must look like a NOP downstream, hence the ctrl masking.
  assign in_ready  = in_ready_q;
  assign out_valid = m_valid_q;
  assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;
  assign out_data  = m_data_q;
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

`ifdef PIPE_STAT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating statistics counters; they stop at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (m_valid_q && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush && (m_valid_q || s_valid_q) && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // Counter flops, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: self-checking bench for pipe_stage_buf (DATA_W=64,
// CTRL_W=8). A negedge scoreboard records every accepted beat and compares it
// against the beat leaving the stage; each scenario task also checks the
// cycle-level outputs it expects. Define PIPE_STAT_EN to cover the counters.
module tb_pipe_stage_buf;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 8;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_STAT_EN
  logic [31:0]       stall_cnt;
  logic [15:0]       flush_cnt;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic [CTRL_W+DATA_W-1:0] sb_q[$];

  pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: inputs change 1 time unit after posedge, so the negedge sees
  // what the next posedge will commit. Departures are popped before arrivals
  // are pushed, and a flush discards whatever is still queued.
  always @(negedge clk) begin
    logic [CTRL_W+DATA_W-1:0] exp_beat;
    if (reset) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check_cnt++;
        if (sb_q.size() == 0) begin
          $display("[TB] FAIL sb_unexpected_beat got=%h expected none", out_data);
        end else begin
          exp_beat = sb_q.pop_front();
          if ({out_ctrl, out_data} !== exp_beat)
            $display("[TB] FAIL sb_order got=%h_%h expected=%h", out_ctrl, out_data, exp_beat);
          else
            pass_cnt++;
        end
      end
      if (!out_valid) begin
        check_cnt++;
        if (out_ctrl !== '0)
          $display("[TB] FAIL bubble_ctrl got=%h expected=00", out_ctrl);
        else
          pass_cnt++;
      end
      if (flush)
        sb_q.delete();
      else if (in_valid && in_ready)
        sb_q.push_back({in_ctrl, in_data});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    #12;
    check_cnt++;
    if ({out_valid, out_ctrl, out_data, in_ready, occupancy} !== {1'b0, 8'h00, 64'h0, 1'b1, 2'd0})
      $display("[TB] FAIL reset_state got v=%b c=%h d=%h r=%b o=%0d expected v=0 c=00 d=0 r=1 o=0",
               out_valid, out_ctrl, out_data, in_ready, occupancy);
    else
      pass_cnt++;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 8'h05;
    for (int i = 1; i <= 8; i++) begin
      in_data = 64'(i);
      check_cnt++;
      if (in_ready !== 1'b1) $display("[TB] FAIL stream_ready got=%b expected=1", in_ready);
      else pass_cnt++;
      step();
      check_cnt++;
      if ({out_valid, out_ctrl, out_data, occupancy} !== {1'b1, 8'h05, 64'(i), 2'd1})
        $display("[TB] FAIL stream_beat%0d got v=%b c=%h d=%h o=%0d expected v=1 c=05 d=%0d o=1",
                 i, out_valid, out_ctrl, out_data, occupancy, i);
      else
        pass_cnt++;
    end
    in_valid = 1'b0;
    step();
    check_cnt++;
    if (out_valid !== 1'b0) $display("[TB] FAIL stream_drain got=%b expected=0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h0C;
    in_data   = 64'h11;
    step();
    in_data = 64'h22;
    step();
    check_cnt++;
    if ({in_ready, occupancy, out_data} !== {1'b0, 2'd2, 64'h11})
      $display("[TB] FAIL bp_full got r=%b o=%0d d=%h expected r=0 o=2 d=11", in_ready, occupancy, out_data);
    else
      pass_cnt++;
    in_data = 64'h33;
    step();
    check_cnt++;
    if ({in_ready, occupancy, out_data} !== {1'b0, 2'd2, 64'h11})
      $display("[TB] FAIL bp_hold got r=%b o=%0d d=%h expected r=0 o=2 d=11", in_ready, occupancy, out_data);
    else
      pass_cnt++;
    out_ready = 1'b1;
    step();
    check_cnt++;
    if ({out_data, in_ready, occupancy} !== {64'h22, 1'b1, 2'd1})
      $display("[TB] FAIL bp_drain1 got d=%h r=%b o=%0d expected d=22 r=1 o=1", out_data, in_ready, occupancy);
    else
      pass_cnt++;
    step();
    in_valid = 1'b0;
    check_cnt++;
    if ({out_valid, out_data} !== {1'b1, 64'h33})
      $display("[TB] FAIL bp_drain2 got v=%b d=%h expected v=1 d=33", out_valid, out_data);
    else
      pass_cnt++;
    step();
    check_cnt++;
    if (occupancy !== 2'd0) $display("[TB] FAIL bp_empty got=%0d expected=0", occupancy);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h3A;
    in_data   = 64'hA1;
    step();
    in_data = 64'hA2;
    step();
    check_cnt++;
    if (occupancy !== 2'd2) $display("[TB] FAIL flush_prefill got=%0d expected=2", occupancy);
    else pass_cnt++;
    flush   = 1'b1;
    in_data = 64'h44;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_cnt++;
    if ({out_valid, out_ctrl, occupancy, in_ready} !== {1'b0, 8'h00, 2'd0, 1'b1})
      $display("[TB] FAIL flush_clear got v=%b c=%h o=%0d r=%b expected v=0 c=00 o=0 r=1",
               out_valid, out_ctrl, occupancy, in_ready);
    else
      pass_cnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_cnt++;
      if (out_valid !== 1'b0) $display("[TB] FAIL flush_no_leak got=%b expected=0", out_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h21;
    in_data   = 64'h61;
    step();
    in_data = 64'h62;
    step();
    in_valid = 1'b0;
    check_cnt++;
    if (occupancy !== 2'd2) $display("[TB] FAIL areset_prefill got=%0d expected=2", occupancy);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    check_cnt++;
    if ({out_valid, out_ctrl, out_data, in_ready, occupancy} !== {1'b0, 8'h00, 64'h0, 1'b1, 2'd0})
      $display("[TB] FAIL areset_clear got v=%b c=%h d=%h r=%b o=%0d expected v=0 c=00 d=0 r=1 o=0",
               out_valid, out_ctrl, out_data, in_ready, occupancy);
    else
      pass_cnt++;
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 8'h0A;
    in_data   = 64'h55;
    step();
    in_valid = 1'b0;
    check_cnt++;
    if ({out_valid, out_ctrl, out_data} !== {1'b1, 8'h0A, 64'h55})
      $display("[TB] FAIL areset_first got v=%b c=%h d=%h expected v=1 c=0a d=55", out_valid, out_ctrl, out_data);
    else
      pass_cnt++;
    step();
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 8'hFF;
    in_data   = 64'h77;
    step();
    in_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check_cnt++;
      if ({out_valid, out_ctrl, out_data} !== {1'b0, 8'h00, 64'h77})
        $display("[TB] FAIL bubble_hold got v=%b c=%h d=%h expected v=0 c=00 d=77", out_valid, out_ctrl, out_data);
      else
        pass_cnt++;
      step();
    end
  endtask

`ifdef PIPE_STAT_EN
  task automatic test_stats();
    #2 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h01;
    in_data   = 64'h88;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    check_cnt++;
    if ({stall_cnt, flush_cnt} !== {32'd5, 16'd1})
      $display("[TB] FAIL stats got stall=%0d flush=%0d expected stall=5 flush=1", stall_cnt, flush_cnt);
    else
      pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_bubble();
`ifdef PIPE_STAT_EN
    test_stats();
`endif
    step();
    check_cnt++;
    if (sb_q.size() != 0) $display("[TB] FAIL sb_leftover got=%0d expected=0", sb_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
